// File: rtl/switch_port_pkg.sv
// Shared definitions for the slide-switch input port.
//   REG_*                    : register selectors decoded from switchaddr[2:1]
//   DEBOUNCE_CYCLES_DEFAULT  : debounce length used unless overridden
package switch_port_pkg;

    localparam logic [1:0] REG_DATA_LO = 2'd0;
    localparam logic [1:0] REG_DATA_HI = 2'd1;
    localparam logic [1:0] REG_CHG_LO  = 2'd2;
    localparam logic [1:0] REG_CHG_HI  = 2'd3;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20000;

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: synchroniser chain, debounce counter and accepted level.
//   switclk      : clock, state updates on the falling edge
//   switrst      : asynchronous active-high reset
//   sw           : raw asynchronous switch level
//   stable       : debounced level
//   rose_or_fell : high during the cycle whose falling edge updates stable
module switch_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic switclk,
    input  logic switrst,
    input  logic sw,
    output logic stable,
    output logic rose_or_fell
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync;
    logic                   mismatch;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        mismatch     = (sync != stable_q);
        cnt_d        = '0;
        stable_d     = stable_q;
        // Combinational so the top can set chg on the same edge stable moves.
        rose_or_fell = mismatch && (cnt_q == CntMax);
        if (rose_or_fell) begin
            stable_d = sync;
        end else if (mismatch) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/switch_port.sv
// Memory-mapped slide-switch input port with sticky read-to-clear change flags.
//   switclk     : clock, falling-edge active
//   switrst     : asynchronous active-high reset
//   switchcs    : chip select from the IO decoder
//   switchread  : read strobe, qualified by switchcs at a falling edge
//   switchaddr  : byte offset, bits [2:1] select DATA_LO/DATA_HI/CHG_LO/CHG_HI
//   switch_i    : raw switch levels
//   switchrdata : registered read data
//   switchirq   : high while any change flag is set
module switch_port
    import switch_port_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 24,
    parameter int unsigned BUS_WIDTH       = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 switclk,
    input  logic                 switrst,
    input  logic                 switchcs,
    input  logic                 switchread,
    input  logic [2:0]           switchaddr,
    input  logic [SW_WIDTH-1:0]  switch_i,
    output logic [BUS_WIDTH-1:0] switchrdata,
    output logic                 switchirq
);

    logic [SW_WIDTH-1:0]    stable, rose_or_fell;
    logic [SW_WIDTH-1:0]    chg_q, chg_d, clr;
    logic [2*BUS_WIDTH-1:0] stable_ext, chg_ext;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   irq_q;
    logic                   rd_en;
    logic [1:0]             sel;
    logic                   unused_addr;

    assign unused_addr = switchaddr[0];
    assign rd_en       = switchcs & switchread;
    assign sel         = switchaddr[2:1];

    for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
        switch_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .switclk      (switclk),
            .switrst      (switrst),
            .sw           (switch_i[g]),
            .stable       (stable[g]),
            .rose_or_fell (rose_or_fell[g])
        );
    end

    always_comb begin
        stable_ext = (2*BUS_WIDTH)'(stable);
        chg_ext    = (2*BUS_WIDTH)'(chg_q);
        clr        = '0;
        rdata_d    = rdata_q;
        if (rd_en) begin
            unique case (sel)
                REG_DATA_LO: rdata_d = stable_ext[BUS_WIDTH-1:0];
                REG_DATA_HI: rdata_d = stable_ext[2*BUS_WIDTH-1:BUS_WIDTH];
                REG_CHG_LO: begin
                    rdata_d                 = chg_ext[BUS_WIDTH-1:0];
                    clr[BUS_WIDTH-1:0]      = '1;
                end
                REG_CHG_HI: begin
                    rdata_d                 = chg_ext[2*BUS_WIDTH-1:BUS_WIDTH];
                    clr[SW_WIDTH-1:BUS_WIDTH] = '1;
                end
                default: ;
            endcase
        end
        // A new change on the clearing edge survives the clear.
        chg_d = (chg_q & ~clr) | rose_or_fell;
    end

    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            chg_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            chg_q   <= chg_d;
            rdata_q <= rdata_d;
            irq_q   <= |chg_d;
        end
    end

    assign switchrdata = rdata_q;
    assign switchirq   = irq_q;

endmodule

// File: tb/tb_switch_port.sv
// Directed self-checking bench for switch_port (SW_WIDTH=24, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Inputs change on the rising edge, the DUT acts on the
// falling edge, outputs are sampled on the following rising edge.
module tb_switch_port;

    logic        switclk = 1'b1;
    logic        switrst;
    logic        switchcs;
    logic        switchread;
    logic [2:0]  switchaddr;
    logic [23:0] switch_i;
    logic [15:0] switchrdata;
    logic        switchirq;

    int checks   = 0;
    int failures = 0;

    switch_port #(
        .SW_WIDTH        (24),
        .BUS_WIDTH       (16),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .switclk     (switclk),
        .switrst     (switrst),
        .switchcs    (switchcs),
        .switchread  (switchread),
        .switchaddr  (switchaddr),
        .switch_i    (switch_i),
        .switchrdata (switchrdata),
        .switchirq   (switchirq)
    );

    always #5 switclk = ~switclk;

    // One falling edge, then return at the following rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge switclk);
            @(posedge switclk);
        end
    endtask

    task automatic do_read(input logic [2:0] a, output logic [15:0] d);
        switchcs   = 1'b1;
        switchread = 1'b1;
        switchaddr = a;
        @(negedge switclk);
        @(posedge switclk);
        d          = switchrdata;
        switchcs   = 1'b0;
        switchread = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int rise;
        switrst    = 1'b1;
        switchcs   = 1'b0;
        switchread = 1'b0;
        switchaddr = 3'b000;
        switch_i   = 24'hFFFFFF;
        #3;
        checks++;
        if (switchrdata !== 16'h0000 || switchirq !== 1'b0) begin
            failures++;
            $display("FAIL reset_immediate: rdata=%h irq=%b, required rdata=0000 irq=0",
                     switchrdata, switchirq);
        end
        @(posedge switclk);
        tick(2);
        switrst = 1'b0;
        rise = 0;
        for (int e = 1; e <= 20 && rise == 0; e++) begin
            tick(1);
            if (switchirq === 1'b1) rise = e;
        end
        checks++;
        if (rise != 6) begin
            failures++;
            $display("FAIL reset_latency: irq rose at edge %0d, required edge 6", rise);
        end
        do_read(3'b000, d);
        checks++;
        if (d !== 16'hFFFF) begin
            failures++;
            $display("FAIL reset_data_lo: got %h, required FFFF", d);
        end
        do_read(3'b010, d);
        checks++;
        if (d !== 16'h00FF) begin
            failures++;
            $display("FAIL reset_data_hi: got %h, required 00FF", d);
        end
    endtask

    // Reset asserted between edges while rdata and irq are nonzero.
    task automatic test_async_reset();
        logic [15:0] d;
        #2;
        switrst  = 1'b1;
        switch_i = 24'h000000;
        #1;
        checks++;
        if (switchrdata !== 16'h0000 || switchirq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: rdata=%h irq=%b, required rdata=0000 irq=0",
                     switchrdata, switchirq);
        end
        @(posedge switclk);
        tick(1);
        switrst = 1'b0;
        tick(8);
        do_read(3'b000, d);
        checks++;
        if (d !== 16'h0000 || switchirq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_after: data_lo=%h irq=%b, required 0000/0", d, switchirq);
        end
    endtask

    task automatic test_debounce();
        logic [15:0] d;
        switch_i = 24'h000008;
        tick(5);
        checks++;
        if (switchirq !== 1'b0) begin
            failures++;
            $display("FAIL debounce_early: irq=%b at edge 5, required 0", switchirq);
        end
        tick(1);
        checks++;
        if (switchirq !== 1'b1) begin
            failures++;
            $display("FAIL debounce_edge6: irq=%b at edge 6, required 1", switchirq);
        end
        do_read(3'b000, d);
        checks++;
        if (d !== 16'h0008) begin
            failures++;
            $display("FAIL debounce_data: got %h, required 0008", d);
        end
        do_read(3'b100, d);
        checks++;
        if (d !== 16'h0008 || switchirq !== 1'b0) begin
            failures++;
            $display("FAIL debounce_chg: chg_lo=%h irq=%b, required 0008/0", d, switchirq);
        end
        // Three-edge glitch on bit 5 must be rejected.
        switch_i = 24'h000028;
        tick(3);
        switch_i = 24'h000008;
        tick(10);
        checks++;
        if (switchirq !== 1'b0) begin
            failures++;
            $display("FAIL glitch_irq: irq=%b, required 0", switchirq);
        end
        do_read(3'b000, d);
        checks++;
        if (d !== 16'h0008) begin
            failures++;
            $display("FAIL glitch_data: got %h, required 0008", d);
        end
        do_read(3'b100, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL glitch_chg: got %h, required 0000", d);
        end
    endtask

    task automatic test_change_flags();
        logic [15:0] d;
        switch_i = 24'h100009;
        tick(8);
        checks++;
        if (switchirq !== 1'b1) begin
            failures++;
            $display("FAIL chg_irq_set: irq=%b, required 1", switchirq);
        end
        do_read(3'b100, d);
        checks++;
        if (d !== 16'h0001 || switchirq !== 1'b1) begin
            failures++;
            $display("FAIL chg_lo: got %h irq=%b, required 0001/1", d, switchirq);
        end
        do_read(3'b110, d);
        checks++;
        if (d !== 16'h0010 || switchirq !== 1'b0) begin
            failures++;
            $display("FAIL chg_hi: got %h irq=%b, required 0010/0", d, switchirq);
        end
        do_read(3'b100, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL chg_lo_reread: got %h, required 0000", d);
        end
        do_read(3'b110, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL chg_hi_reread: got %h, required 0000", d);
        end
    endtask

    // Bit 2 qualifies on the 6th edge, which is also the CHG_LO read edge.
    task automatic test_collision();
        logic [15:0] d;
        switch_i = 24'h10000D;
        tick(5);
        checks++;
        if (switchirq !== 1'b0) begin
            failures++;
            $display("FAIL coll_pre: irq=%b, required 0", switchirq);
        end
        do_read(3'b100, d);
        checks++;
        if (d !== 16'h0000 || switchirq !== 1'b1) begin
            failures++;
            $display("FAIL coll_read: got %h irq=%b, required 0000/1", d, switchirq);
        end
        do_read(3'b100, d);
        checks++;
        if (d !== 16'h0004 || switchirq !== 1'b0) begin
            failures++;
            $display("FAIL coll_next: got %h irq=%b, required 0004/0", d, switchirq);
        end
    endtask

    task automatic test_hold_select();
        logic [15:0] d;
        do_read(3'b000, d);
        checks++;
        if (d !== 16'h000D) begin
            failures++;
            $display("FAIL sel_data_lo: got %h, required 000D", d);
        end
        switchcs   = 1'b1;
        switchread = 1'b0;
        switchaddr = 3'b010;
        tick(1);
        checks++;
        if (switchrdata !== 16'h000D) begin
            failures++;
            $display("FAIL hold_cs_only: got %h, required 000D", switchrdata);
        end
        switchcs   = 1'b0;
        switchread = 1'b1;
        tick(1);
        checks++;
        if (switchrdata !== 16'h000D) begin
            failures++;
            $display("FAIL hold_read_only: got %h, required 000D", switchrdata);
        end
        switchread = 1'b0;
        do_read(3'b011, d);
        checks++;
        if (d !== 16'h0010) begin
            failures++;
            $display("FAIL sel_addr3: got %h, required 0010", d);
        end
        do_read(3'b001, d);
        checks++;
        if (d !== 16'h000D) begin
            failures++;
            $display("FAIL sel_addr1: got %h, required 000D", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1, d2;
        switch_i = 24'h10000F;
        tick(8);
        switchcs   = 1'b1;
        switchread = 1'b1;
        switchaddr = 3'b100;
        tick(1);
        d1 = switchrdata;
        tick(1);
        d2 = switchrdata;
        switchcs   = 1'b0;
        switchread = 1'b0;
        checks++;
        if (d1 !== 16'h0002) begin
            failures++;
            $display("FAIL b2b_first: got %h, required 0002", d1);
        end
        checks++;
        if (d2 !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_second: got %h, required 0000", d2);
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_debounce();
        test_change_flags();
        test_collision();
        test_hold_select();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
